if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, issues word fetches to instruction memory and holds the IF/ID pipeline register. The decoder controller in ID reads the opcode and function fields from this register. Stall, flush and branch/jump redirects from the hazard unit and later stages are resolved here.

---
 rtl/if_stage_if.sv | 11 +
 rtl/if_stage.sv | 112 +++++++++++
 tb/tb_if_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory fetch port shared by the fetch stage (master) and the memory (slave).
interface if_stage_if;
  // req/ready: a fetch completes on a rising edge where req && ready; req may drop or addr change while ready=0
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory through a one-entry
// skid buffer, and holds the IF/ID pipeline register with stall, flush and redirect handling.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  if_stage_if.master  imem,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic [5:0]  ifid_opcode,
  output logic [5:0]  ifid_func,
  output logic        state_dbg
);

  typedef enum logic {
    FETCH = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic        ifid_valid_n;
  logic [31:0] ifid_instr_n, ifid_pc4_n;
  logic        hs;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem.req    = rst_n && (state == FETCH);
  assign imem.addr   = pc;
  assign hs          = imem.req && imem.ready;
  assign ifid_opcode = ifid_instr[31:26];
  assign ifid_func   = ifid_instr[5:0];
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      ifid_valid <= 1'b0;
      ifid_instr <= 32'h0;
      ifid_pc4   <= 32'h0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      ifid_valid <= ifid_valid_n;
      ifid_instr <= ifid_instr_n;
      ifid_pc4   <= ifid_pc4_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    ifid_valid_n = ifid_valid;
    ifid_instr_n = ifid_instr;
    ifid_pc4_n   = ifid_pc4;

    // A redirect discards both a completing fetch and a held instruction.
    if (redirect) begin
      pc_n    = {redirect_pc[31:2], 2'b00};
      state_n = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (hs) begin
            pc_n = pc + 32'd4;
            if (stall) begin
              state_n      = HELD;
              skid_instr_n = imem.rdata;
              skid_pc_n    = pc;
            end
          end
        end
        HELD: begin
          if (!stall) state_n = FETCH;
        end
      endcase
    end

    if (flush || (!stall && (redirect || (state == FETCH && !hs)))) begin
      ifid_valid_n = 1'b0;
      ifid_instr_n = 32'h0;
      ifid_pc4_n   = 32'h0;
    end else if (!stall) begin
      ifid_valid_n = 1'b1;
      if (state == HELD) begin
        ifid_instr_n = skid_instr;
        ifid_pc4_n   = skid_pc + 32'd4;
      end else begin
        ifid_instr_n = imem.rdata;
        ifid_pc4_n   = pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then random stall/flush/redirect/ready traffic.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect, ready;
  logic [31:0] redirect_pc;
  logic [31:0] pc, ifid_instr, ifid_pc4;
  logic        ifid_valid, state_dbg;
  logic [5:0]  ifid_opcode, ifid_func;

  int n_checks = 0;
  int n_errors = 0;

  if_stage_if imem();

  assign imem.ready = ready;
  assign imem.rdata = 32'h0000_0020 + imem.addr;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .pc          (pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_opcode (ifid_opcode),
    .ifid_func   (ifid_func),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: program order view of the fetch stage
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_v;
  logic [63:0] skid_q[$];
  logic [98:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0020 + a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_v = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
    skid_q.delete();
  endtask

  task automatic model_step();
    logic        done, have;
    logic [31:0] c_instr, c_pc;
    done = (skid_q.size() == 0) && ready;
    have = 1'b0; c_instr = 32'h0; c_pc = 32'h0;
    if (!redirect) begin
      if (skid_q.size() != 0) begin
        have = 1'b1; c_instr = skid_q[0][63:32]; c_pc = skid_q[0][31:0];
      end else if (done) begin
        have = 1'b1; c_instr = mem_word(m_pc); c_pc = m_pc;
      end
    end
    if (flush || (!stall && !have)) begin
      m_v = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
    end else if (!stall) begin
      m_v = 1'b1; m_instr = c_instr; m_pc4 = c_pc + 32'd4;
    end
    if (redirect) begin
      m_pc = redirect_pc & ~32'd3;
      skid_q.delete();
    end else if (skid_q.size() != 0) begin
      if (!stall) void'(skid_q.pop_front());
    end else if (done) begin
      if (stall) skid_q.push_back({mem_word(m_pc), m_pc});
      m_pc = m_pc + 32'd4;
    end
    exp_q.push_back({(skid_q.size() == 0), (skid_q.size() != 0), m_v, m_pc, m_instr, m_pc4});
  endtask

  task automatic compare(input string tag);
    logic [98:0] e;
    logic [31:0] ei;
    if (exp_q.size() == 0) begin
      check({tag, ".exp_q_empty"}, 32'd0, 32'd1);
      return;
    end
    e  = exp_q.pop_front();
    ei = e[63:32];
    check({tag, ".req"},    {31'b0, imem.req},   {31'b0, e[98]});
    check({tag, ".held"},   {31'b0, state_dbg},  {31'b0, e[97]});
    check({tag, ".valid"},  {31'b0, ifid_valid}, {31'b0, e[96]});
    check({tag, ".pc"},     pc,                  e[95:64]);
    check({tag, ".addr"},   imem.addr,           e[95:64]);
    check({tag, ".instr"},  ifid_instr,          ei);
    check({tag, ".pc4"},    ifid_pc4,            e[31:0]);
    check({tag, ".opcode"}, {26'b0, ifid_opcode}, {26'b0, ei[31:26]});
    check({tag, ".func"},   {26'b0, ifid_func},  {26'b0, ei[5:0]});
  endtask

  // One clock: drive at the falling edge, predict, check 1 time unit after the rising edge.
  task automatic cycle(input string tag, input logic st, input logic fl, input logic rd,
                       input logic [31:0] rpc, input logic rdy);
    stall = st; flush = fl; redirect = rd; redirect_pc = rpc; ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    compare(tag);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".pc"},    pc,                  32'h0);
    check({tag, ".req"},   {31'b0, imem.req},   32'h0);
    check({tag, ".valid"}, {31'b0, ifid_valid}, 32'h0);
    check({tag, ".instr"}, ifid_instr,          32'h0);
    check({tag, ".pc4"},   ifid_pc4,            32'h0);
    check({tag, ".held"},  {31'b0, state_dbg},  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; ready = 1'b0;
    model_reset();
    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release.req", {31'b0, imem.req}, 32'h1);

    // Streaming up to pc=8, then three wait states
    for (int i = 0; i < 2; i++) cycle("stream", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("wait", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle("wait_done", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("wait_done.pc4_12", ifid_pc4, 32'd12);
    cycle("stream2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Stall across a completing fetch at pc=16, then release
    for (int i = 0; i < 2; i++) cycle("stall", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle("stall_release", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("stall_release.pc4_20", ifid_pc4, 32'd20);

    // Enter HELD again, then redirect while held
    cycle("stall_b", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle("redir_held", 1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
    check("redir_held.addr_100", imem.addr, 32'h0000_0100);
    for (int i = 0; i < 3; i++) cycle("redir_after", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush together with stall
    cycle("flush_stall", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle("flush_stall_rdy", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle("flush_release", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Wrap at the top of the address space
    cycle("wrap_redir", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cycle("wrap_fetch", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_fetch.pc4_0", ifid_pc4, 32'h0);
    cycle("wrap_next", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    cycle("post_reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        st, fl, rd, rdy;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 25);
      fl  = ($urandom_range(0, 99) < 10);
      rd  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 70);
      rpc = $urandom();
      cycle("rand", st, fl, rd, rpc, rdy);
    end

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
